// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW hazard stall/flush/forwarding control for a 4-stage pipeline.
// Optional operand forwarding is enabled by defining HAZ_FORWARD_EN.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset_input,
    input  logic [15:0] fede_instr,
    input  logic [3:0]  exe_opcode,
    input  logic [3:0]  exe_rd,
    input  logic [3:0]  dm_opcode,
    input  logic [3:0]  dm_rd,
    input  logic        branch_taken,
    output logic        pc_hold,
    output logic        fede_hold,
    output logic        fede_flush,
    output logic        deexe_bubble,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [1:0]  ctrl_state,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    logic [3:0] de_op, de_rs1, de_rs2;
    logic       reads_rs1, reads_rs2;
    logic       exe_wr, dm_wr;
    logic       exe_hit_a, exe_hit_b, dm_hit_a, dm_hit_b;
    logic       stall;
    logic       pc_hold_c, fede_hold_c, fede_flush_c, deexe_bubble_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    function automatic logic is_writer(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hD, 4'hF: is_writer = 1'b1;
            default: is_writer = 1'b0;
        endcase
    endfunction

    assign de_op  = fede_instr[15:12];
    assign de_rs1 = fede_instr[7:4];
    assign de_rs2 = fede_instr[3:0];

    // NOP and 1101 read nothing; the load reads only its base register.
    assign reads_rs1 = (de_op != 4'h0) && (de_op != 4'hD);
    assign reads_rs2 = reads_rs1 && (de_op != 4'h7);

    assign exe_wr = is_writer(exe_opcode);
    assign dm_wr  = is_writer(dm_opcode);

    assign exe_hit_a = reads_rs1 && exe_wr && (exe_rd == de_rs1);
    assign exe_hit_b = reads_rs2 && exe_wr && (exe_rd == de_rs2);
    assign dm_hit_a  = reads_rs1 && dm_wr  && (dm_rd  == de_rs1);
    assign dm_hit_b  = reads_rs2 && dm_wr  && (dm_rd  == de_rs2);

`ifdef HAZ_FORWARD_EN
    // Only a load in EXE cannot be bypassed: its data appears one stage too late.
    assign stall = (exe_opcode == 4'h7) && (exe_hit_a || exe_hit_b);

    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (state_q != ST_FLUSH) begin
            if (exe_hit_a)     fwd_a_c = 2'b01;
            else if (dm_hit_a) fwd_a_c = 2'b10;
            if (exe_hit_b)     fwd_b_c = 2'b01;
            else if (dm_hit_b) fwd_b_c = 2'b10;
        end
    end
`else
    assign stall   = exe_hit_a || exe_hit_b || dm_hit_a || dm_hit_b;
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        pc_hold_c      = 1'b0;
        fede_hold_c    = 1'b0;
        fede_flush_c   = 1'b0;
        deexe_bubble_c = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                fede_flush_c = 1'b1;
                state_d      = ST_RUN;
            end
            default: begin
                if (branch_taken) begin
                    fede_flush_c   = 1'b1;
                    deexe_bubble_c = 1'b1;
                    state_d        = ST_FLUSH;
                end else if (stall) begin
                    pc_hold_c      = 1'b1;
                    fede_hold_c    = 1'b1;
                    deexe_bubble_c = 1'b1;
                    state_d        = ST_STALL;
                end else begin
                    state_d        = ST_RUN;
                end
            end
        endcase
        if (pc_hold_c && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_input) begin
        if (!reset_input) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational controls are gated so reset clears them without waiting for a clock.
    assign pc_hold      = reset_input & pc_hold_c;
    assign fede_hold    = reset_input & fede_hold_c;
    assign fede_flush   = reset_input & fede_flush_c;
    assign deexe_bubble = reset_input & deexe_bubble_c;
    assign fwd_a_sel    = reset_input ? fwd_a_c : 2'b00;
    assign fwd_b_sel    = reset_input ? fwd_b_c : 2'b00;
    assign ctrl_state   = state_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized check of pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_input;
    logic [15:0] fede_instr;
    logic [3:0]  exe_opcode, exe_rd, dm_opcode, dm_rd;
    logic        branch_taken;
    logic        pc_hold, fede_hold, fede_flush, deexe_bubble;
    logic [1:0]  fwd_a_sel, fwd_b_sel, ctrl_state;
    logic [7:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] writer_mask = 16'hA1FE;
    logic [15:0] rs1_mask    = 16'hDFFE;
    logic [15:0] rs2_mask    = 16'hDF7E;

    int m_mode;
    int m_cnt;
    int m_next;
    logic e_hold, e_flush, e_bubble;
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset_input(reset_input), .fede_instr(fede_instr),
        .exe_opcode(exe_opcode), .exe_rd(exe_rd), .dm_opcode(dm_opcode), .dm_rd(dm_rd),
        .branch_taken(branch_taken), .pc_hold(pc_hold), .fede_hold(fede_hold),
        .fede_flush(fede_flush), .deexe_bubble(deexe_bubble), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        int op, r1, r2;
        bit ra, rb, ea, eb, da, db, stl;
        op = int'(fede_instr[15:12]);
        r1 = int'(fede_instr[7:4]);
        r2 = int'(fede_instr[3:0]);
        ra = rs1_mask[op];
        rb = rs2_mask[op];
        ea = ra && writer_mask[exe_opcode] && (int'(exe_rd) == r1);
        eb = rb && writer_mask[exe_opcode] && (int'(exe_rd) == r2);
        da = ra && writer_mask[dm_opcode] && (int'(dm_rd) == r1);
        db = rb && writer_mask[dm_opcode] && (int'(dm_rd) == r2);
`ifdef HAZ_FORWARD_EN
        stl  = (exe_opcode == 4'd7) && (ea || eb);
        e_fa = ea ? 2'd1 : (da ? 2'd2 : 2'd0);
        e_fb = eb ? 2'd1 : (db ? 2'd2 : 2'd0);
`else
        stl  = ea || eb || da || db;
        e_fa = 2'd0;
        e_fb = 2'd0;
`endif
        e_hold = 0; e_flush = 0; e_bubble = 0;
        if (m_mode == 2) begin
            e_flush = 1; e_fa = 0; e_fb = 0; m_next = 0;
        end else if (branch_taken) begin
            e_flush = 1; e_bubble = 1; m_next = 2;
        end else if (stl) begin
            e_hold = 1; e_bubble = 1; m_next = 1;
        end else begin
            m_next = 0;
        end
    endtask

    // Inputs are set at the falling edge; outputs checked 1 time unit later and after the next rising edge.
    task automatic step();
        #1;
        model_eval();
        chk("pc_hold", pc_hold, e_hold);
        chk("fede_hold", fede_hold, e_hold);
        chk("fede_flush", fede_flush, e_flush);
        chk("deexe_bubble", deexe_bubble, e_bubble);
        chk("fwd_a_sel", fwd_a_sel, e_fa);
        chk("fwd_b_sel", fwd_b_sel, e_fb);
        @(posedge clk);
        if (e_hold && m_cnt < 255) m_cnt++;
        m_mode = m_next;
        #1;
        chk("ctrl_state", ctrl_state, m_mode[1:0]);
        chk("stall_cnt", stall_cnt, m_cnt[7:0]);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] fi, input logic [3:0] eo, input logic [3:0] er,
                          input logic [3:0] dmo, input logic [3:0] dmr, input logic br);
        fede_instr = fi; exe_opcode = eo; exe_rd = er;
        dm_opcode = dmo; dm_rd = dmr; branch_taken = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_input = 1'b0;
        m_mode = 0;
        m_cnt = 0;
        @(negedge clk);
        reset_input = 1'b1;
    endtask

    initial begin
        reset_input = 1'b0;
        set_in(16'h0000, 0, 0, 0, 0, 0);
        m_mode = 0;
        m_cnt = 0;
        #2;
        chk("rst_pc_hold", pc_hold, 0);
        chk("rst_flush", fede_flush, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        reset_input = 1'b1;

`ifdef HAZ_FORWARD_EN
        set_in(16'h2034, 4'd1, 4'd3, 0, 0, 0);
        #1;
        chk("dir_fwd_a", fwd_a_sel, 2'b01);
        chk("dir_fwd_b", fwd_b_sel, 2'b00);
        chk("dir_fwd_nostall", pc_hold, 0);
        step();

        do_reset();
        set_in(16'h3015, 4'd7, 4'd5, 0, 0, 0);
        #1;
        chk("dir_lu_hold", pc_hold, 1);
        chk("dir_lu_bubble", deexe_bubble, 1);
        step();
        chk("dir_lu_state", ctrl_state, 2'b01);
        chk("dir_lu_cnt", stall_cnt, 8'd1);
        set_in(16'h3015, 0, 0, 4'd7, 4'd5, 0);
        #1;
        chk("dir_lu_fwd_b", fwd_b_sel, 2'b10);
        chk("dir_lu_release", pc_hold, 0);
        step();
        chk("dir_lu_run", ctrl_state, 2'b00);
`else
        do_reset();
        set_in(16'h3020, 4'd1, 4'd2, 0, 0, 0);
        step();
        set_in(16'h3020, 0, 0, 4'd1, 4'd2, 0);
        #1;
        chk("dir_nf_stall2", pc_hold, 1);
        chk("dir_nf_fwd", fwd_a_sel, 2'b00);
        step();
        set_in(16'h3020, 0, 0, 0, 0, 0);
        step();
        chk("dir_nf_cnt", stall_cnt, 8'd2);
        chk("dir_nf_run", ctrl_state, 2'b00);
`endif

        do_reset();
        set_in(16'h3015, 4'd7, 4'd5, 0, 0, 1);
        #1;
        chk("dir_br_pc_hold", pc_hold, 0);
        chk("dir_br_flush", fede_flush, 1);
        chk("dir_br_bubble", deexe_bubble, 1);
        step();
        chk("dir_br_state", ctrl_state, 2'b10);
        set_in(16'h3015, 4'd7, 4'd5, 0, 0, 1);
        #1;
        chk("dir_fl_flush", fede_flush, 1);
        chk("dir_fl_nohold", pc_hold, 0);
        step();
        chk("dir_fl_run", ctrl_state, 2'b00);

        for (int i = 0; i < 400; i++) begin
            set_in({4'($urandom_range(15)), 4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))},
                   4'($urandom_range(15)), 4'($urandom_range(3)),
                   4'($urandom_range(15)), 4'($urandom_range(3)),
                   ($urandom_range(7) == 0));
            step();
        end

        do_reset();
        set_in(16'h3020, 4'd7, 4'd2, 0, 0, 0);
        for (int i = 0; i < 300; i++) step();
        chk("sat_cnt", stall_cnt, 8'd255);
        chk("sat_state", ctrl_state, 2'b01);
        #2;
        reset_input = 1'b0;
        m_mode = 0;
        m_cnt = 0;
        #1;
        chk("async_pc_hold", pc_hold, 0);
        chk("async_fede_hold", fede_hold, 0);
        chk("async_bubble", deexe_bubble, 0);
        chk("async_flush", fede_flush, 0);
        chk("async_fwd_a", fwd_a_sel, 0);
        chk("async_fwd_b", fwd_b_sel, 0);
        chk("async_state", ctrl_state, 0);
        chk("async_cnt", stall_cnt, 0);
        @(negedge clk);
        reset_input = 1'b1;
        step();
        chk("post_rst_cnt", stall_cnt, 8'd1);
        for (int i = 0; i < 20; i++) begin
            set_in({4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(3)), 4'($urandom_range(3))},
                   4'($urandom_range(15)), 4'($urandom_range(3)),
                   4'($urandom_range(15)), 4'($urandom_range(3)),
                   ($urandom_range(3) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
